// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA window mixer: raster counter width,
// default window bounds, 3-bit colour patterns and the flash FSM state type.
package vga_pkg;

    localparam int H_W = 11;

    localparam int DEF_XPOS_START = 192;
    localparam int DEF_XPOS_END   = 448;
    localparam int DEF_YPOS_START = 48;
    localparam int DEF_YPOS_END   = 432;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb3_t;

    localparam rgb3_t BORDER_RGB = 3'b110;
    localparam rgb3_t FLASH_RGB  = 3'b001;
    localparam rgb3_t WHITE_RGB  = 3'b111;

    typedef enum logic {
        FL_IDLE  = 1'b0,
        FL_FLASH = 1'b1
    } flash_state_t;

endpackage

// File: rtl/vga_window_mixer_if.sv
// Pixel-stream bundle between the renderer/raster counters and the window mixer.
// score_level is only present when SCORE_BAR_EN is defined.
interface vga_window_mixer_if
    import vga_pkg::*;
#(
    parameter int COLOR_W = 1
);

    logic               count;
    logic               blank;
    logic [H_W-1:0]     hcounter;
    logic [H_W-1:0]     vcounter;
    logic [COLOR_W-1:0] red_in;
    logic [COLOR_W-1:0] green_in;
    logic [COLOR_W-1:0] blue_in;
    logic               flash_req;
`ifdef SCORE_BAR_EN
    logic [7:0]         score_level;
`endif
    logic [COLOR_W-1:0] red_out;
    logic [COLOR_W-1:0] green_out;
    logic [COLOR_W-1:0] blue_out;
    logic               flash_phase;

    modport master (
        output count, blank, hcounter, vcounter,
        output red_in, green_in, blue_in, flash_req,
`ifdef SCORE_BAR_EN
        output score_level,
`endif
        input  red_out, green_out, blue_out, flash_phase
    );

    modport slave (
        input  count, blank, hcounter, vcounter,
        input  red_in, green_in, blue_in, flash_req,
`ifdef SCORE_BAR_EN
        input  score_level,
`endif
        output red_out, green_out, blue_out, flash_phase
    );

endinterface

// File: rtl/vga_flash_ctrl.sv
// Border flash controller: detects frame ticks, counts frames while flashing
// and toggles flash_phase every FLASH_FRAMES frames.
module vga_flash_ctrl
    import vga_pkg::*;
#(
    parameter int FLASH_FRAMES = 16
) (
    input  logic           pixel_clk,
    input  logic           reset,
    input  logic           count,
    input  logic           flash_req,
    input  logic [H_W-1:0] hcounter,
    input  logic [H_W-1:0] vcounter,
    output logic           flash_phase
);

    localparam int              CNT_W = $clog2(FLASH_FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FLASH_FRAMES - 1);

    flash_state_t     state;
    logic [CNT_W-1:0] frame_cnt;
    logic             frame_tick;

    assign frame_tick = count && (hcounter == '0) && (vcounter == '0);

    // Dropping the request clears immediately, independent of the pixel strobe.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state       <= FL_IDLE;
            frame_cnt   <= '0;
            flash_phase <= 1'b0;
        end else if (!flash_req) begin
            state       <= FL_IDLE;
            frame_cnt   <= '0;
            flash_phase <= 1'b0;
        end else if (count) begin
            case (state)
                FL_IDLE: begin
                    state     <= FL_FLASH;
                    frame_cnt <= '0;
                end
                FL_FLASH: begin
                    if (frame_tick) begin
                        if (frame_cnt == LAST) begin
                            frame_cnt   <= '0;
                            flash_phase <= ~flash_phase;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: state <= FL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vga_window_mixer.sv
// VGA output stage: two-stage strobe-gated pipeline choosing field colour,
// border colour (optionally flashing) or blank. Optional score bar: SCORE_BAR_EN.
module vga_window_mixer
    import vga_pkg::*;
#(
    parameter int COLOR_W    = 1,
    parameter int XPOS_START = DEF_XPOS_START,
    parameter int XPOS_END   = DEF_XPOS_END,
    parameter int YPOS_START = DEF_YPOS_START,
    parameter int YPOS_END   = DEF_YPOS_END,
    parameter logic [3*COLOR_W-1:0] BORDER_COLOR =
        {{COLOR_W{BORDER_RGB.r}}, {COLOR_W{BORDER_RGB.g}}, {COLOR_W{BORDER_RGB.b}}},
    parameter logic [3*COLOR_W-1:0] FLASH_COLOR =
        {{COLOR_W{FLASH_RGB.r}}, {COLOR_W{FLASH_RGB.g}}, {COLOR_W{FLASH_RGB.b}}},
    parameter int FLASH_FRAMES = 16
) (
    input logic               pixel_clk,
    input logic               reset,
    vga_window_mixer_if.slave bus
);

    localparam logic [H_W-1:0] X_S = H_W'(XPOS_START);
    localparam logic [H_W-1:0] X_E = H_W'(XPOS_END);
    localparam logic [H_W-1:0] Y_S = H_W'(YPOS_START);
    localparam logic [H_W-1:0] Y_E = H_W'(YPOS_END);

    logic                   row_in;
    logic                   in_win;
    logic                   bar;
    logic                   flash_phase;
    logic [3*COLOR_W-1:0]   border_color;

    logic                   vld_p1;
    logic                   blank_p1;
    logic                   in_win_p1;
    logic                   bar_p1;
    logic [3*COLOR_W-1:0]   rgb_p1;
    logic [3*COLOR_W-1:0]   rgb_p2;

    vga_flash_ctrl #(
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_flash (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .count       (bus.count),
        .flash_req   (bus.flash_req),
        .hcounter    (bus.hcounter),
        .vcounter    (bus.vcounter),
        .flash_phase (flash_phase)
    );

    // START >= END makes both compares impossible to satisfy: an empty window.
    assign row_in = (bus.vcounter >= Y_S) && (bus.vcounter < Y_E);
    assign in_win = row_in && (bus.hcounter >= X_S) && (bus.hcounter < X_E);

`ifdef SCORE_BAR_EN
    localparam logic [H_W+1:0] BAR_LO = (H_W + 2)'(XPOS_END + 2);
    logic [H_W+1:0] h_ext;
    logic [H_W+1:0] bar_hi;
    assign h_ext  = {2'b00, bus.hcounter};
    assign bar_hi = BAR_LO + {5'b00000, bus.score_level};
    assign bar    = row_in && (h_ext >= BAR_LO) && (h_ext < bar_hi);
`else
    assign bar = 1'b0;
`endif

    assign border_color = flash_phase ? FLASH_COLOR : BORDER_COLOR;

    // Stage 1: capture raster classification and field colour.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            vld_p1    <= 1'b0;
            blank_p1  <= 1'b0;
            in_win_p1 <= 1'b0;
            bar_p1    <= 1'b0;
            rgb_p1    <= '0;
        end else if (bus.count) begin
            vld_p1    <= 1'b1;
            blank_p1  <= bus.blank;
            in_win_p1 <= in_win;
            bar_p1    <= bar;
            rgb_p1    <= {bus.red_in, bus.green_in, bus.blue_in};
        end
    end

    // Stage 2: final colour select; nothing leaves until stage 1 holds a real pixel.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            rgb_p2 <= '0;
        end else if (bus.count) begin
            if (!vld_p1 || blank_p1) begin
                rgb_p2 <= '0;
            end else if (in_win_p1) begin
                rgb_p2 <= rgb_p1;
            end else if (bar_p1) begin
                rgb_p2 <= '1;
            end else begin
                rgb_p2 <= border_color;
            end
        end
    end

    assign {bus.red_out, bus.green_out, bus.blue_out} = rgb_p2;
    assign bus.flash_phase = flash_phase;

endmodule
